// File: rtl/triangle_rasterizer_if.sv
// Stream interface between the projection stage, the rasterizer and the
// frame-buffer writer: triangle input stream plus pixel output stream.
interface triangle_rasterizer_if #(
  parameter int COLOR_W = 8
) ();
  logic                    tri_valid;
  logic                    tri_ready;
  logic [2:0][1:0][9:0]    proj_triangle;
  logic                    clip;
  logic [COLOR_W-1:0]      tri_color;
  logic                    pix_valid;
  logic                    pix_ready;
  logic [9:0]              pix_x;
  logic [9:0]              pix_y;
  logic [COLOR_W-1:0]      pix_color;

  // Rasterizer side: consumes triangles, produces pixels.
  modport slave (
    input  tri_valid, proj_triangle, clip, tri_color, pix_ready,
    output tri_ready, pix_valid, pix_x, pix_y, pix_color
  );

  // Environment side: produces triangles, consumes pixels.
  modport master (
    output tri_valid, proj_triangle, clip, tri_color, pix_ready,
    input  tri_ready, pix_valid, pix_x, pix_y, pix_color
  );
endinterface

// File: rtl/triangle_rasterizer.sv
// Triangle rasterizer: latches one screen-space triangle, computes a
// screen-clamped bounding box, walks it in raster order evaluating three
// edge functions per pixel and streams every covered pixel downstream.
module triangle_rasterizer #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int COLOR_W  = 8,
  parameter int CNT_W    = 19
) (
  input  logic                 Clk,
  input  logic                 Reset,
  triangle_rasterizer_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     pix_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SCAN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [9:0] X_MAX = 10'(SCREEN_W - 1);
  localparam logic [9:0] Y_MAX = 10'(SCREEN_H - 1);

  // Edge function (xb-xa)(py-ya) - (yb-ya)(px-xa): 11-bit signed differences,
  // 22-bit products, 23-bit signed result.
  function automatic logic signed [22:0] edge_fn(
    input logic [9:0] xa, input logic [9:0] ya,
    input logic [9:0] xb, input logic [9:0] yb,
    input logic [9:0] px, input logic [9:0] py
  );
    logic signed [10:0] d0, d1, d2, d3;
    logic signed [21:0] w0, w1, w2, w3, p0, p1;
    d0 = $signed({1'b0, xb}) - $signed({1'b0, xa});
    d1 = $signed({1'b0, py}) - $signed({1'b0, ya});
    d2 = $signed({1'b0, yb}) - $signed({1'b0, ya});
    d3 = $signed({1'b0, px}) - $signed({1'b0, xa});
    w0 = {{11{d0[10]}}, d0};
    w1 = {{11{d1[10]}}, d1};
    w2 = {{11{d2[10]}}, d2};
    w3 = {{11{d3[10]}}, d3};
    p0 = w0 * w1;
    p1 = w2 * w3;
    return {p0[21], p0} - {p1[21], p1};
  endfunction

  function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    logic [9:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    logic [9:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  state_t               state_r;
  logic [2:0][1:0][9:0] v_r;
  logic [COLOR_W-1:0]   color_r;
  logic [9:0]           minx_r, miny_r, maxx_r, maxy_r;
  logic [9:0]           cx_r, cy_r;
  logic [CNT_W-1:0]     pix_count_r;
  logic                 tri_ready_r, busy_r, done_r;

  logic [9:0]           minx_s, miny_s, maxx_s, maxy_s, rawx_s, rawy_s;
  logic signed [22:0]   area_s, e0_s, e1_s, e2_s;
  logic                 inside_s, pix_valid_s, advance_s;

  // Bounding box, winding area and per-pixel coverage from the latched vertices.
  always_comb begin
    minx_s      = min3(v_r[0][0], v_r[1][0], v_r[2][0]);
    miny_s      = min3(v_r[0][1], v_r[1][1], v_r[2][1]);
    rawx_s      = max3(v_r[0][0], v_r[1][0], v_r[2][0]);
    rawy_s      = max3(v_r[0][1], v_r[1][1], v_r[2][1]);
    maxx_s      = (rawx_s > X_MAX) ? X_MAX : rawx_s;
    maxy_s      = (rawy_s > Y_MAX) ? Y_MAX : rawy_s;
    area_s      = edge_fn(v_r[0][0], v_r[0][1], v_r[1][0], v_r[1][1], v_r[2][0], v_r[2][1]);
    e0_s        = edge_fn(v_r[0][0], v_r[0][1], v_r[1][0], v_r[1][1], cx_r, cy_r);
    e1_s        = edge_fn(v_r[1][0], v_r[1][1], v_r[2][0], v_r[2][1], cx_r, cy_r);
    e2_s        = edge_fn(v_r[2][0], v_r[2][1], v_r[0][0], v_r[0][1], cx_r, cy_r);
    inside_s    = !e0_s[22] && !e1_s[22] && !e2_s[22];
    pix_valid_s = (state_r == SCAN) && inside_s;
    advance_s   = !inside_s || bus.pix_ready;
  end

  // Control FSM: accept, set up, scan the box in raster order, pulse done.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r     <= IDLE;
      v_r         <= '0;
      color_r     <= '0;
      minx_r      <= 10'd0;
      miny_r      <= 10'd0;
      maxx_r      <= 10'd0;
      maxy_r      <= 10'd0;
      cx_r        <= 10'd0;
      cy_r        <= 10'd0;
      pix_count_r <= '0;
      tri_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.tri_valid && tri_ready_r) begin
            v_r         <= bus.proj_triangle;
            color_r     <= bus.tri_color;
            pix_count_r <= '0;
            tri_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (bus.clip) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= SETUP;
            end
          end
        end
        SETUP: begin
          if ((area_s == 23'sd0) || (minx_s > X_MAX) || (miny_s > Y_MAX)) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            // Negative winding: swap vertices 1 and 2 so edges face inward.
            if (area_s[22]) begin
              v_r[1] <= v_r[2];
              v_r[2] <= v_r[1];
            end
            minx_r  <= minx_s;
            miny_r  <= miny_s;
            maxx_r  <= maxx_s;
            maxy_r  <= maxy_s;
            cx_r    <= minx_s;
            cy_r    <= miny_s;
            state_r <= SCAN;
          end
        end
        SCAN: begin
          if (pix_valid_s && bus.pix_ready) begin
            pix_count_r <= pix_count_r + CNT_W'(1);
          end
          if (advance_s) begin
            if (cx_r == maxx_r) begin
              if (cy_r == maxy_r) begin
                state_r <= DONE;
                done_r  <= 1'b1;
              end else begin
                cx_r <= minx_r;
                cy_r <= cy_r + 10'd1;
              end
            end else begin
              cx_r <= cx_r + 10'd1;
            end
          end
        end
        DONE: begin
          done_r      <= 1'b0;
          tri_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          done_r      <= 1'b0;
          tri_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.tri_ready = tri_ready_r;
  assign bus.pix_valid = pix_valid_s;
  assign bus.pix_x     = cx_r;
  assign bus.pix_y     = cy_r;
  assign bus.pix_color = color_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign pix_count     = pix_count_r;

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Directed testbench for triangle_rasterizer: each scenario task drives one
// or more triangles and compares the pixel stream and timing against
// hand-computed expectations.
module tb_triangle_rasterizer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        busy, done;
  logic [18:0] pix_count;

  int checks = 0;
  int failures = 0;

  triangle_rasterizer_if #(.COLOR_W(8)) bus ();

  triangle_rasterizer #(
    .SCREEN_W(640), .SCREEN_H(480), .COLOR_W(8), .CNT_W(19)
  ) dut (
    .Clk(clk), .Reset(reset), .bus(bus),
    .busy(busy), .done(done), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  // Results collected by run_tri.
  int   rx[$];
  int   ry[$];
  int   done_cycle, got_count, offscreen, color_bad, valid_cycles, stall_seen;
  logic accept_ok, post_done_ok;

  int exp_x[10] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
  int exp_y[10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};

  // Called at a negedge: presents one triangle, then records per-cycle
  // activity; cycle n is the cycle after acceptance edge n-1.
  task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input logic clip_in,
                         input logic [7:0] col, input int sx, input int sy, input int sn);
    logic [2:0][1:0][9:0] t;
    int left;
    t[0][0] = 10'(x0); t[0][1] = 10'(y0);
    t[1][0] = 10'(x1); t[1][1] = 10'(y1);
    t[2][0] = 10'(x2); t[2][1] = 10'(y2);
    rx.delete(); ry.delete();
    done_cycle = -1; got_count = -1; offscreen = 0; color_bad = 0;
    valid_cycles = 0; stall_seen = 0; left = sn;
    bus.proj_triangle = t; bus.clip = clip_in; bus.tri_color = col;
    bus.tri_valid = 1'b1; bus.pix_ready = 1'b1;
    #1 accept_ok = bus.tri_ready;
    @(posedge clk);
    #1 bus.tri_valid = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (bus.pix_valid && bus.pix_x == 10'(sx) && bus.pix_y == 10'(sy) && left > 0) begin
        bus.pix_ready = 1'b0;
        left--;
        stall_seen++;
      end else begin
        bus.pix_ready = 1'b1;
      end
      if (bus.pix_valid) valid_cycles++;
      if (bus.pix_valid && bus.pix_ready) begin
        rx.push_back(int'(bus.pix_x));
        ry.push_back(int'(bus.pix_y));
        if (bus.pix_x > 10'd639 || bus.pix_y > 10'd479) offscreen++;
        if (bus.pix_color !== col) color_bad++;
      end
      if (done === 1'b1) begin
        done_cycle = cyc;
        got_count  = int'(pix_count);
        break;
      end
    end
    bus.pix_ready = 1'b1;
    @(negedge clk);
    post_done_ok = (done === 1'b0) && (bus.tri_ready === 1'b1) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    bus.tri_valid = 1'b0; bus.clip = 1'b0; bus.tri_color = 8'h00;
    bus.proj_triangle = '0; bus.pix_ready = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.pix_valid, done, busy} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got valid/done/busy=%b expected 000", {bus.pix_valid, done, busy});
    end
    checks++;
    if (bus.tri_ready !== 1'b1) begin
      failures++; $display("FAIL reset_tri_ready got %b expected 1", bus.tri_ready);
    end
    checks++;
    if ({pix_count, bus.pix_x, bus.pix_y, bus.pix_color} !== 47'd0) begin
      failures++; $display("FAIL reset_values got count=%0d x=%0d y=%0d color=%0h expected 0", pix_count, bus.pix_x, bus.pix_y, bus.pix_color);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_case1(input string name, input int exp_done);
    checks++;
    if (accept_ok !== 1'b1) begin
      failures++; $display("FAIL %s_accept got tri_ready=%b expected 1", name, accept_ok);
    end
    checks++;
    if (rx.size() != 10) begin
      failures++; $display("FAIL %s_npix got %0d expected 10", name, rx.size());
    end
    for (int i = 0; i < 10 && i < rx.size(); i++) begin
      checks++;
      if (rx[i] != exp_x[i] || ry[i] != exp_y[i]) begin
        failures++; $display("FAIL %s_pix%0d got (%0d,%0d) expected (%0d,%0d)", name, i, rx[i], ry[i], exp_x[i], exp_y[i]);
      end
    end
    checks++;
    if (done_cycle != exp_done) begin
      failures++; $display("FAIL %s_done_cycle got %0d expected %0d", name, done_cycle, exp_done);
    end
    checks++;
    if (got_count != 10) begin
      failures++; $display("FAIL %s_pix_count got %0d expected 10", name, got_count);
    end
    checks++;
    if (color_bad != 0 || post_done_ok !== 1'b1) begin
      failures++; $display("FAIL %s_color_post got color_bad=%0d post_done_ok=%b expected 0/1", name, color_bad, post_done_ok);
    end
  endtask

  task automatic test_basic();
    run_tri(0, 0, 3, 0, 0, 3, 1'b0, 8'hA5, -1, -1, 0);
    check_case1("basic", 18);
  endtask

  task automatic test_winding();
    run_tri(0, 0, 0, 3, 3, 0, 1'b0, 8'h3C, -1, -1, 0);
    check_case1("winding", 18);
  endtask

  task automatic test_stall();
    run_tri(0, 0, 3, 0, 0, 3, 1'b0, 8'h5A, 1, 1, 3);
    check_case1("stall", 21);
    checks++;
    if (stall_seen != 3) begin
      failures++; $display("FAIL stall_held got %0d held cycles at (1,1) expected 3", stall_seen);
    end
  endtask

  task automatic test_reject(input string name, input int x0, input int y0, input int x1,
                             input int y1, input int x2, input int y2, input logic c, input int exp_done);
    run_tri(x0, y0, x1, y1, x2, y2, c, 8'h11, -1, -1, 0);
    checks++;
    if (valid_cycles != 0) begin
      failures++; $display("FAIL %s_valid got %0d pixel cycles expected 0", name, valid_cycles);
    end
    checks++;
    if (done_cycle != exp_done) begin
      failures++; $display("FAIL %s_done_cycle got %0d expected %0d", name, done_cycle, exp_done);
    end
    checks++;
    if (got_count != 0 || accept_ok !== 1'b1) begin
      failures++; $display("FAIL %s_count got %0d accept=%b expected 0/1", name, got_count, accept_ok);
    end
  endtask

  task automatic test_clamp();
    int mnx, mxx, mny, mxy;
    run_tri(630, 470, 700, 470, 630, 500, 1'b0, 8'hC3, -1, -1, 0);
    mnx = 1023; mxx = 0; mny = 1023; mxy = 0;
    foreach (rx[i]) begin
      if (rx[i] < mnx) mnx = rx[i];
      if (rx[i] > mxx) mxx = rx[i];
      if (ry[i] < mny) mny = ry[i];
      if (ry[i] > mxy) mxy = ry[i];
    end
    checks++;
    if (rx.size() != 100 || got_count != 100) begin
      failures++; $display("FAIL clamp_npix got %0d/%0d expected 100", rx.size(), got_count);
    end
    checks++;
    if (mnx != 630 || mxx != 639 || mny != 470 || mxy != 479 || offscreen != 0) begin
      failures++; $display("FAIL clamp_range got x %0d..%0d y %0d..%0d off=%0d expected 630..639 470..479 0", mnx, mxx, mny, mxy, offscreen);
    end
    checks++;
    if (done_cycle != 102) begin
      failures++; $display("FAIL clamp_done_cycle got %0d expected 102", done_cycle);
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    logic [2:0][1:0][9:0] t;
    t[0][0] = 10'd0; t[0][1] = 10'd0;
    t[1][0] = 10'd3; t[1][1] = 10'd0;
    t[2][0] = 10'd0; t[2][1] = 10'd3;
    bus.proj_triangle = t; bus.clip = 1'b0; bus.tri_color = 8'h77;
    bus.tri_valid = 1'b1; bus.pix_ready = 1'b1;
    @(posedge clk);
    #1 bus.tri_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.pix_valid !== 1'b1 || bus.pix_x !== 10'd2) begin
      failures++; $display("FAIL midrst_scanning got valid=%b x=%0d expected 1/2", bus.pix_valid, bus.pix_x);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.pix_valid !== 1'b0 || bus.tri_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL midrst_idle got valid=%b ready=%b busy=%b expected 0/1/0", bus.pix_valid, bus.tri_ready, busy);
    end
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1 || bus.pix_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL midrst_quiet got %0d cycles with done/pix_valid expected 0", seen);
    end
    run_tri(0, 0, 3, 0, 0, 3, 1'b0, 8'h99, -1, -1, 0);
    check_case1("after_rst", 18);
  endtask

  task automatic test_back_to_back();
    run_tri(0, 0, 3, 0, 0, 3, 1'b0, 8'h42, -1, -1, 0);
    check_case1("b2b_first", 18);
    test_reject("b2b_clip", 5, 5, 9, 9, 1, 7, 1'b1, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_winding();
    test_reject("clip", 10, 10, 20, 10, 10, 20, 1'b1, 1);
    test_reject("collinear", 0, 0, 5, 5, 10, 10, 1'b0, 2);
    test_reject("offscreen", 700, 10, 800, 10, 700, 50, 1'b0, 2);
    test_clamp();
    test_stall();
    test_reset_mid_scan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/triangle_rasterizer.md
Name: triangle_rasterizer

Overview:
Consumes one projected screen-space triangle (three 10-bit x/y vertices plus clip flag) from the projection stage. Computes a screen-clamped bounding box and walks it in raster order, evaluating three edge functions per pixel. Emits every covered pixel, with the triangle's colour, to the frame-buffer writer over a valid/ready stream. Sits between the projection stage and the frame-buffer write arbiter.

Parameters:
SCREEN_W, 640, horizontal resolution; x clamp is SCREEN_W-1
SCREEN_H, 480, vertical resolution; y clamp is SCREEN_H-1
COLOR_W, 8, pixel colour width
CNT_W, 19, width of per-triangle pixel counter

Ports:
Clk  in  1  clock, all logic on rising edge
Reset  in  1  synchronous, active-low reset
tri_valid  in  1  upstream triangle available
tri_ready  out  1  block can accept a triangle
proj_triangle  in  [2:0][1:0][9:0]  vertex k: [k][0]=x, [k][1]=y, unsigned pixels
clip  in  1  triangle rejected upstream; sampled with proj_triangle
tri_color  in  COLOR_W  colour for all pixels of this triangle
pix_valid  out  1  pixel available
pix_ready  in  1  downstream accepts pixel
pix_x  out  10  pixel x
pix_y  out  10  pixel y
pix_color  out  COLOR_W  latched tri_color
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at end of every accepted triangle
pix_count  out  CNT_W  pixels emitted for the last triangle; valid while done is high, holds until next acceptance

Behaviour:
- Reset (Reset==0 at edge): state IDLE; pix_valid=0, done=0, busy=0, pix_count=0, pix_x=pix_y=0, pix_color=0. Reset mid-triangle aborts it: no further pixels, no done pulse.
- IDLE: tri_ready=1; tri_ready=0 in every other state. Acceptance is tri_valid&&tri_ready at an edge; latch vertices, clip, tri_color; clear pix_count.
  - clip=1: go to DONE.
  - clip=0: go to SETUP.
- SETUP (1 cycle):
  - Bounding box: min/max of the three x and y; max clamped to SCREEN_W-1 / SCREEN_H-1.
  - Signed double area A = (x1-x0)(y2-y0) - (x2-x0)(y1-y0): 11-bit signed differences, 22-bit products, 23-bit signed sum.
  - A==0 (degenerate) or minx>SCREEN_W-1 or miny>SCREEN_H-1: go to DONE.
  - A<0: swap vertices 1 and 2 so both windings rasterise identically.
  - Otherwise cx=minx, cy=miny; go to SCAN.
- SCAN: one pixel per cycle at full throughput.
  - Ei = (xb-xa)(cy-ya) - (yb-ya)(cx-xa) for edges (0,1), (1,2), (2,0); 23-bit signed.
  - inside = all Ei >= 0. Edges are inclusive; no top-left rule.
  - pix_valid = inside; pix_x=cx, pix_y=cy, pix_color=latched colour.
  - Advance when !inside or pix_ready. While pix_valid&&!pix_ready, pix_x/pix_y/pix_color stay stable and cx/cy do not move.
  - Each handshake increments pix_count.
  - Advance order: cx++. At cx==maxx: cx=minx, cy++. Advancing from (maxx,maxy): go to DONE.
- DONE (1 cycle): done=1, pix_valid=0; return to IDLE. A new triangle may be accepted on the following edge.
- Timing (pix_ready=1, acceptance at edge 0):
  - SETUP in cycle 1; pixels scanned in cycles 2 .. 1+bboxW*bboxH; done in cycle 2+bboxW*bboxH.
  - clip: done in cycle 1.
  - degenerate or off-screen: done in cycle 2.
- Vertex coordinates 640..1023 / 480..1023 are legal inputs; they only affect the clamped box.

Test Plan:
1. Vertices (0,0),(3,0),(0,3), clip=0, pix_ready=1 -> exactly 10 pixels in order (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(0,2),(1,2),(0,3); done in cycle 18; pix_count=10.
2. Same triangle with vertices 1/2 swapped -> identical pixel stream and timing.
3. clip=1, any vertices -> zero pix_valid, done in cycle 1, pix_count=0. Collinear (0,0),(5,5),(10,10) -> zero pixels, done in cycle 2.
4. Vertices (630,470),(700,470),(630,500) -> exactly 100 pixels covering x 630..639, y 470..479; none outside the screen; pix_count=100.
5. Case 1 with pix_ready held low for 3 cycles while pixel (1,1) is presented -> pix_x=1, pix_y=1 held; no pixel lost or duplicated; done delayed by 3 cycles.
6. Reset driven low for one cycle during SCAN of case 1 -> next cycle IDLE, pix_valid=0, tri_ready=1, no done pulse. A following triangle then rasterises normally.
